// File: rtl/reg_read_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// reg_read_arbiter_pkg
// Shared widths for the register-read arbiter and its round-robin helper.
//   REG_ID_W       architectural register id width (x0..x31)
//   ROB_WIDTH_BIT  width of a reorder-buffer entry id
//   DATA_W         register value width
//   rr_index()     wrap-around index used by the arbiter and pointer update
// -----------------------------------------------------------------------------
package reg_read_arbiter_pkg;

  localparam int REG_ID_W      = 5;
  localparam int ROB_WIDTH_BIT = 4;
  localparam int DATA_W        = 32;

  // (base + off) mod n, for base < n and off < n
  function automatic int rr_index(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/reg_read_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: grants the first asserted request at or
// after ptr, wrapping around. The pointer register lives in the parent.
// Ports:
//   req    [N]   request vector
//   ptr    [PW]  highest-priority index this cycle (must be < N)
//   grant  [N]   one-hot grant, all-zero when no request
//   any          at least one request granted
// -----------------------------------------------------------------------------
module rr_arbiter
  import reg_read_arbiter_pkg::*;
#(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          any
);

  logic found;

  // Walk priority offsets from ptr; the inner compare selects the single
  // requester sitting at that offset so every index stays loop-constant.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int off = 0; off < N; off++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && (i == rr_index(int'(ptr), off, N)) && req[i]) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
    any = found;
  end

endmodule

// File: rtl/reg_read_arbiter.sv
// -----------------------------------------------------------------------------
// reg_read_arbiter
// Shares the register file's two read ports between NUM_REQ requesters.
// Two-stage pipeline:
//   S1 accept : round-robin pick, latch owner and source ids
//   S2 read   : drive rf_id1/rf_id2 from S1, register the returned operands
// A request accepted at edge T produces resp_valid after edge T+1.
// Ports:
//   clk_in, rst_n_in          clock, synchronous active-low reset
//   rdy_in                    low freezes all state (and req_ready = 0)
//   rob_clear                 kills in-flight work (only when rdy_in high)
//   req_valid/req_rs1/req_rs2 requester i uses bits [5i+4:5i] of the id buses
//   req_ready                 one-hot combinational grant (accept cycle)
//   rf_id*/rf_val*/rf_has_dep*/rf_dep*   register file read interface
//   resp_*                    registered operand bundle, single-cycle pulse
// -----------------------------------------------------------------------------
module reg_read_arbiter
  import reg_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ROB_W   = ROB_WIDTH_BIT
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         rdy_in,
  input  logic                         rob_clear,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [REG_ID_W*NUM_REQ-1:0]  req_rs1,
  input  logic [REG_ID_W*NUM_REQ-1:0]  req_rs2,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [REG_ID_W-1:0]          rf_id1,
  output logic [REG_ID_W-1:0]          rf_id2,
  input  logic [DATA_W-1:0]            rf_val1,
  input  logic [DATA_W-1:0]            rf_val2,
  input  logic                         rf_has_dep1,
  input  logic                         rf_has_dep2,
  input  logic [ROB_W-1:0]             rf_dep1,
  input  logic [ROB_W-1:0]             rf_dep2,
  output logic                         resp_valid,
  output logic [NUM_REQ-1:0]           resp_grant,
  output logic [DATA_W-1:0]            resp_val1,
  output logic [DATA_W-1:0]            resp_val2,
  output logic                         resp_has_dep1,
  output logic                         resp_has_dep2,
  output logic [ROB_W-1:0]             resp_dep1,
  output logic [ROB_W-1:0]             resp_dep2
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0]    rr_ptr_q,        rr_ptr_d;
  logic                s1_valid_q,      s1_valid_d;
  logic [NUM_REQ-1:0]  s1_grant_q,      s1_grant_d;
  logic [REG_ID_W-1:0] s1_rs1_q,        s1_rs1_d;
  logic [REG_ID_W-1:0] s1_rs2_q,        s1_rs2_d;
  logic                resp_valid_q,    resp_valid_d;
  logic [NUM_REQ-1:0]  resp_grant_q,    resp_grant_d;
  logic [DATA_W-1:0]   resp_val1_q,     resp_val1_d;
  logic [DATA_W-1:0]   resp_val2_q,     resp_val2_d;
  logic                resp_has_dep1_q, resp_has_dep1_d;
  logic                resp_has_dep2_q, resp_has_dep2_d;
  logic [ROB_W-1:0]    resp_dep1_q,     resp_dep1_d;
  logic [ROB_W-1:0]    resp_dep2_q,     resp_dep2_d;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [NUM_REQ-1:0]  arb_grant;
  logic                arb_any;
  logic                advance;
  logic [REG_ID_W-1:0] sel_rs1;
  logic [REG_ID_W-1:0] sel_rs2;
  int                  gidx;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PTR_W)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (arb_grant),
    .any   (arb_any)
  );

  // A stall or a flush cycle accepts nothing; req_ready never looks at rf_*.
  assign advance   = rdy_in & ~rob_clear;
  assign req_ready = advance ? arb_grant : '0;

  always_comb begin
    sel_rs1 = '0;
    sel_rs2 = '0;
    gidx    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_rs1 = req_rs1[REG_ID_W*i +: REG_ID_W];
        sel_rs2 = req_rs2[REG_ID_W*i +: REG_ID_W];
        gidx    = i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register file read (S2) with x0 override
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] op_val1, op_val2;
  logic              op_has_dep1, op_has_dep2;
  logic [ROB_W-1:0]  op_dep1, op_dep2;

  assign rf_id1 = s1_valid_q ? s1_rs1_q : '0;
  assign rf_id2 = s1_valid_q ? s1_rs2_q : '0;

  // x0 is hardwired zero and never waits on the ROB, whatever the RF says.
  always_comb begin
    op_val1     = rf_val1;
    op_has_dep1 = rf_has_dep1;
    op_dep1     = rf_dep1;
    op_val2     = rf_val2;
    op_has_dep2 = rf_has_dep2;
    op_dep2     = rf_dep2;
    if (s1_rs1_q == '0) begin
      op_val1     = '0;
      op_has_dep1 = 1'b0;
      op_dep1     = '0;
    end
    if (s1_rs2_q == '0) begin
      op_val2     = '0;
      op_has_dep2 = 1'b0;
      op_dep2     = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    rr_ptr_d        = rr_ptr_q;
    s1_valid_d      = s1_valid_q;
    s1_grant_d      = s1_grant_q;
    s1_rs1_d        = s1_rs1_q;
    s1_rs2_d        = s1_rs2_q;
    resp_valid_d    = resp_valid_q;
    resp_grant_d    = resp_grant_q;
    resp_val1_d     = resp_val1_q;
    resp_val2_d     = resp_val2_q;
    resp_has_dep1_d = resp_has_dep1_q;
    resp_has_dep2_d = resp_has_dep2_q;
    resp_dep1_d     = resp_dep1_q;
    resp_dep2_d     = resp_dep2_q;

    if (rdy_in) begin
      if (rob_clear) begin
        // Pointer is left alone so fairness is not disturbed by a flush.
        s1_valid_d   = 1'b0;
        s1_grant_d   = '0;
        resp_valid_d = 1'b0;
        resp_grant_d = '0;
      end else begin
        s1_valid_d = arb_any;
        s1_grant_d = arb_grant;
        if (arb_any) begin
          s1_rs1_d = sel_rs1;
          s1_rs2_d = sel_rs2;
          rr_ptr_d = PTR_W'(rr_index(gidx, 1, NUM_REQ));
        end

        resp_valid_d = s1_valid_q;
        resp_grant_d = s1_valid_q ? s1_grant_q : '0;
        if (s1_valid_q) begin
          resp_val1_d     = op_val1;
          resp_val2_d     = op_val2;
          resp_has_dep1_d = op_has_dep1;
          resp_has_dep2_d = op_has_dep2;
          resp_dep1_d     = op_dep1;
          resp_dep2_d     = op_dep2;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      rr_ptr_q        <= '0;
      s1_valid_q      <= 1'b0;
      s1_grant_q      <= '0;
      s1_rs1_q        <= '0;
      s1_rs2_q        <= '0;
      resp_valid_q    <= 1'b0;
      resp_grant_q    <= '0;
      resp_val1_q     <= '0;
      resp_val2_q     <= '0;
      resp_has_dep1_q <= 1'b0;
      resp_has_dep2_q <= 1'b0;
      resp_dep1_q     <= '0;
      resp_dep2_q     <= '0;
    end else begin
      rr_ptr_q        <= rr_ptr_d;
      s1_valid_q      <= s1_valid_d;
      s1_grant_q      <= s1_grant_d;
      s1_rs1_q        <= s1_rs1_d;
      s1_rs2_q        <= s1_rs2_d;
      resp_valid_q    <= resp_valid_d;
      resp_grant_q    <= resp_grant_d;
      resp_val1_q     <= resp_val1_d;
      resp_val2_q     <= resp_val2_d;
      resp_has_dep1_q <= resp_has_dep1_d;
      resp_has_dep2_q <= resp_has_dep2_d;
      resp_dep1_q     <= resp_dep1_d;
      resp_dep2_q     <= resp_dep2_d;
    end
  end

  assign resp_valid    = resp_valid_q;
  assign resp_grant    = resp_grant_q;
  assign resp_val1     = resp_val1_q;
  assign resp_val2     = resp_val2_q;
  assign resp_has_dep1 = resp_has_dep1_q;
  assign resp_has_dep2 = resp_has_dep2_q;
  assign resp_dep1     = resp_dep1_q;
  assign resp_dep2     = resp_dep2_q;

endmodule
